// File: rtl/memoria_dados_param.sv
// Byte-addressed single-port data memory for the MEM stage: byte/half/word loads and stores,
// signed or unsigned, registered read, and a hardware clear of the whole array after every reset.
module memoria_dados_param #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 256,
  parameter int BITS_END     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               requisicao,
  input  logic               escrita,
  input  logic [2:0]         modo,
  input  logic [31:0]        memEndereco,
  input  logic [31:0]        memValor,
  output logic [LARGURA-1:0] saida,
  output logic               saidaValida,
  output logic               ocupado,
  output logic               erro
);

  localparam int FAIXAS = LARGURA / 8;

  typedef enum logic {LIMPA, PRONTO} estado_t;

  estado_t             estado, prox_estado;
  logic [BITS_END-1:0] contador;
  logic [LARGURA-1:0]  mem [PROFUNDIDADE];

  logic [BITS_END-1:0] indice;
  logic [1:0]          faixa;
  logic                modo_legal, alinhado, valido, aceita;
  logic                wr_en;
  logic [BITS_END-1:0] wr_idx;
  logic [FAIXAS-1:0]   wr_be;
  logic [LARGURA-1:0]  wr_dado;
  logic [LARGURA-1:0]  palavra, deslocado, lido;
  logic                unused_end;

  // Upper address bits are deliberately ignored so addresses wrap modulo the array size.
  assign indice     = memEndereco[BITS_END+1:2];
  assign faixa      = memEndereco[1:0];
  assign unused_end = ^memEndereco[31:BITS_END+2];

  always_comb begin
    modo_legal = 1'b0;
    alinhado   = 1'b1;
    case (modo)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: modo_legal = 1'b1;
      default:                                modo_legal = 1'b0;
    endcase
    case (modo[1:0])
      2'b01:   alinhado = ~faixa[0];
      2'b10:   alinhado = (faixa == 2'b00);
      default: alinhado = 1'b1;
    endcase
  end

  assign valido  = modo_legal & alinhado;
  assign aceita  = requisicao & (estado == PRONTO);
  assign ocupado = (estado == LIMPA);

  // Single write port shared by the clear sequence and accepted stores.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = indice;
    wr_be   = '0;
    wr_dado = memValor;
    if (estado == LIMPA) begin
      wr_en   = 1'b1;
      wr_idx  = contador;
      wr_be   = '1;
      wr_dado = '0;
    end else if (aceita && escrita && valido) begin
      wr_en = 1'b1;
      case (modo[1:0])
        2'b00: begin
          wr_be   = 4'b0001 << faixa;
          wr_dado = {4{memValor[7:0]}};
        end
        2'b01: begin
          wr_be   = faixa[1] ? 4'b1100 : 4'b0011;
          wr_dado = {2{memValor[15:0]}};
        end
        default: wr_be = '1;
      endcase
    end
  end

  // NOTE: the array has no reset term; the clear FSM zeroes it, keeping it mappable to RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < FAIXAS; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_dado[8*i +: 8];
      end
    end
  end

  assign palavra   = mem[indice];
  assign deslocado = palavra >> {faixa, 3'b000};

  always_comb begin
    lido = palavra;
    case (modo)
      3'b000:  lido = {{24{deslocado[7]}}, deslocado[7:0]};
      3'b001:  lido = {{16{deslocado[15]}}, deslocado[15:0]};
      3'b100:  lido = {24'b0, deslocado[7:0]};
      3'b101:  lido = {16'b0, deslocado[15:0]};
      default: lido = palavra;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= LIMPA;
      contador <= '0;
    end else begin
      estado <= prox_estado;
      if (estado == LIMPA) contador <= contador + 1'b1;
    end
  end

  always_comb begin
    prox_estado = estado;
    if (estado == LIMPA && contador == BITS_END'(PROFUNDIDADE - 1)) prox_estado = PRONTO;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      saida       <= '0;
      saidaValida <= 1'b0;
      erro        <= 1'b0;
    end else begin
      saidaValida <= aceita & ~escrita & valido;
      erro        <= aceita & ~valido;
      if (aceita && !escrita && valido) saida <= lido;
    end
  end

endmodule

// File: tb/tb_memoria_dados_param.sv
// Directed bench for memoria_dados_param: clear timing, load/store extension, errors, wrap, resets.
module tb_memoria_dados_param;

  logic        clock, reset, requisicao, escrita;
  logic [2:0]  modo;
  logic [31:0] memEndereco, memValor, saida;
  logic        saidaValida, ocupado, erro;

  int tests = 0;
  int fails = 0;

  memoria_dados_param #(.LARGURA(32), .PROFUNDIDADE(256), .BITS_END(8)) dut (
    .clock(clock), .reset(reset), .requisicao(requisicao), .escrita(escrita),
    .modo(modo), .memEndereco(memEndereco), .memValor(memValor), .saida(saida),
    .saidaValida(saidaValida), .ocupado(ocupado), .erro(erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       nome;
    logic        esc;
    logic [2:0]  modo;
    logic [31:0] addr;
    logic [31:0] val;
    logic        vld;
    logic        err;
    logic [31:0] saida;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nome, act, exp);
    end
  endtask

  task automatic add(input string nome, input logic esc, input logic [2:0] m,
                     input logic [31:0] a, input logic [31:0] v,
                     input logic vld, input logic err, input logic [31:0] s);
    vec_t t;
    t.nome = nome; t.esc = esc; t.modo = m; t.addr = a; t.val = v;
    t.vld = vld; t.err = err; t.saida = s;
    vecs.push_back(t);
  endtask

  // Called at a negedge; the request is taken at the next posedge, outputs sampled at the following negedge.
  task automatic req(input logic esc, input logic [2:0] m, input logic [31:0] a, input logic [31:0] v);
    requisicao  = 1'b1;
    escrita     = esc;
    modo        = m;
    memEndereco = a;
    memValor    = v;
    @(negedge clock);
  endtask

  // Counts cycles with ocupado=1 (bounded) and records any output pulse seen meanwhile.
  task automatic wait_clear(output int n, output logic viu);
    n   = 0;
    viu = saidaValida | erro;
    while (ocupado && n < 1000) begin
      @(negedge clock);
      n++;
      viu = viu | saidaValida | erro;
    end
  endtask

  int   n;
  logic viu;

  initial begin
    reset = 1'b0; requisicao = 1'b0; escrita = 1'b0; modo = 3'b010;
    memEndereco = '0; memValor = '0;
    repeat (2) @(negedge clock);
    check("reset saida", saida, 32'h0);
    check("reset saidaValida", {31'b0, saidaValida}, 32'h0);
    check("reset erro", {31'b0, erro}, 32'h0);
    check("reset ocupado", {31'b0, ocupado}, 32'h1);

    // Release with a load held on the bus: it must be ignored for the whole clear.
    requisicao = 1'b1; escrita = 1'b0; modo = 3'b010; memEndereco = 32'h10;
    reset = 1'b1;
    wait_clear(n, viu);
    requisicao = 1'b0;
    check("clear cycles", n, 256);
    check("no pulse while busy", {31'b0, viu}, 32'h0);

    add("lw 3fc",        1'b0, 3'b010, 32'h3FC, 32'h0,        1'b1, 1'b0, 32'h00000000);
    add("sw 10",         1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000);
    add("lb 13",         1'b0, 3'b000, 32'h013, 32'h0,        1'b1, 1'b0, 32'hFFFFFFDE);
    add("lbu 13",        1'b0, 3'b100, 32'h013, 32'h0,        1'b1, 1'b0, 32'h000000DE);
    add("lh 12",         1'b0, 3'b001, 32'h012, 32'h0,        1'b1, 1'b0, 32'hFFFFDEAD);
    add("lhu 10",        1'b0, 3'b101, 32'h010, 32'h0,        1'b1, 1'b0, 32'h0000BEEF);
    add("sb 11",         1'b1, 3'b000, 32'h011, 32'hFFFFFF55, 1'b0, 1'b0, 32'h0000BEEF);
    add("lw 10 after sb",1'b0, 3'b010, 32'h010, 32'h0,        1'b1, 1'b0, 32'hDEAD55EF);
    add("sw 20",         1'b1, 3'b010, 32'h020, 32'h11223344, 1'b0, 1'b0, 32'hDEAD55EF);
    add("sh 22",         1'b1, 3'b001, 32'h022, 32'h0000CAFE, 1'b0, 1'b0, 32'hDEAD55EF);
    add("lw 20 after sh",1'b0, 3'b010, 32'h020, 32'h0,        1'b1, 1'b0, 32'hCAFE3344);
    add("lbu 21",        1'b0, 3'b100, 32'h021, 32'h0,        1'b1, 1'b0, 32'h00000033);
    add("lb 23",         1'b0, 3'b000, 32'h023, 32'h0,        1'b1, 1'b0, 32'hFFFFFFCA);
    add("lw 12 misalign",1'b0, 3'b010, 32'h012, 32'h0,        1'b0, 1'b1, 32'hFFFFFFCA);
    add("lh 21 misalign",1'b0, 3'b001, 32'h021, 32'h0,        1'b0, 1'b1, 32'hFFFFFFCA);
    add("modo 011",      1'b0, 3'b011, 32'h010, 32'h0,        1'b0, 1'b1, 32'hFFFFFFCA);
    add("sw 02 misalign",1'b1, 3'b010, 32'h002, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFCA);
    add("lw 00 intact",  1'b0, 3'b010, 32'h000, 32'h0,        1'b1, 1'b0, 32'h00000000);
    add("sh 23 misalign",1'b1, 3'b101, 32'h023, 32'h0000FFFF, 1'b0, 1'b1, 32'h00000000);
    add("lw 20 intact",  1'b0, 3'b010, 32'h020, 32'h0,        1'b1, 1'b0, 32'hCAFE3344);
    add("sw 00",         1'b1, 3'b010, 32'h000, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFE3344);
    add("lw 400 wrap",   1'b0, 3'b010, 32'h400, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D);
    add("lb 403 wrap",   1'b0, 3'b000, 32'h403, 32'h0,        1'b1, 1'b0, 32'hFFFFFFCA);
    add("lhu 402 wrap",  1'b0, 3'b101, 32'h402, 32'h0,        1'b1, 1'b0, 32'h0000CAFE);

    foreach (vecs[i]) begin
      req(vecs[i].esc, vecs[i].modo, vecs[i].addr, vecs[i].val);
      check({vecs[i].nome, " saidaValida"}, {31'b0, saidaValida}, {31'b0, vecs[i].vld});
      check({vecs[i].nome, " erro"}, {31'b0, erro}, {31'b0, vecs[i].err});
      check({vecs[i].nome, " saida"}, saida, vecs[i].saida);
    end
    requisicao = 1'b0;
    @(negedge clock);
    check("saidaValida is a pulse", {31'b0, saidaValida}, 32'h0);

    // Reset from PRONTO, then a second reset at clear count 100: clear must restart from zero.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    check("busy at count 100", {31'b0, ocupado}, 32'h1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wait_clear(n, viu);
    check("restart clear cycles", n, 256);
    check("restart no pulse", {31'b0, viu}, 32'h0);
    req(1'b0, 3'b010, 32'h020, 32'h0);
    check("lw 20 cleared valid", {31'b0, saidaValida}, 32'h1);
    check("lw 20 cleared", saida, 32'h0);

    // Reset arriving while a load is in flight: the load is discarded.
    req(1'b1, 3'b010, 32'h004, 32'h89ABCDEF);
    req(1'b0, 3'b010, 32'h004, 32'h0);
    check("lw 04", saida, 32'h89ABCDEF);
    requisicao = 1'b1; escrita = 1'b0; modo = 3'b010; memEndereco = 32'h004;
    #2 reset = 1'b0;
    @(negedge clock);
    requisicao = 1'b0;
    check("inflight saidaValida", {31'b0, saidaValida}, 32'h0);
    check("inflight saida reset", saida, 32'h0);
    check("inflight ocupado", {31'b0, ocupado}, 32'h1);
    reset = 1'b1;
    wait_clear(n, viu);
    check("third clear cycles", n, 256);
    check("third clear no pulse", {31'b0, viu}, 32'h0);
    req(1'b0, 3'b010, 32'h004, 32'h0);
    requisicao = 1'b0;
    check("lw 04 cleared valid", {31'b0, saidaValida}, 32'h1);
    check("lw 04 cleared", saida, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memoria_dados_param.md
Name: memoria_dados_param

Overview:
Parametrised synchronous data memory for the MEM stage of the pipeline. It replaces the fixed 32x32 combinational store with a configurable-depth, byte-addressed, single-port memory. It supports byte, halfword and word accesses, signed or unsigned, with a registered read. After every reset, a hardware clear sequence zeroes the whole array before the block accepts any request.

Parameters:
LARGURA, 32, data word width in bits; fixed at 32 for this generation, with 4 byte lanes
PROFUNDIDADE, 256, number of words; must be a power of two, >= 2
BITS_END, 8, log2(PROFUNDIDADE); word-index width

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
requisicao  input  1  request valid; sampled only when ocupado=0
escrita  input  1  1=store, 0=load; qualified by requisicao
modo  input  3  000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; other codes illegal
memEndereco  input  32  byte address
memValor  input  32  store data, right-aligned
saida  output  32  load result, extended to 32 bits
saidaValida  output  1  one-cycle pulse: saida holds a new load result
ocupado  output  1  clear sequence running; requests ignored
erro  output  1  one-cycle pulse: accepted request was misaligned or had an illegal mode

Behaviour:
- Reset (reset=0, asynchronous): saida=0, saidaValida=0, erro=0, ocupado=1, FSM to LIMPA, clear counter=0. Array contents are undefined until the clear sequence finishes.
- FSM LIMPA: each clock writes 0 to word[contador], then contador+1. When contador = PROFUNDIDADE-1 is written, the next state is PRONTO and ocupado drops on the same edge. The sequence takes exactly PROFUNDIDADE cycles after reset release.
- FSM PRONTO: ocupado=0. No transition back to LIMPA except by reset.
- Reset asserted mid-clear or mid-access: the sequence restarts from contador=0 and any in-flight load is discarded, with no saidaValida.
- Requests while ocupado=1: no memory change, no saidaValida, no erro.
- Word index = memEndereco[BITS_END+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*PROFUNDIDADE.
- Byte lane = memEndereco[1:0], little-endian: lane 0 = bits 7:0.
- Alignment rules:
  - Half requires memEndereco[0]=0.
  - Word requires memEndereco[1:0]=00.
  - Violation or illegal modo: request accepted but has no effect. The next cycle gives erro=1 and saidaValida=0, and saida keeps its previous value.
- Store (escrita=1):
  - Byte writes memValor[7:0] to the selected lane.
  - Half writes memValor[15:0] to lanes {1,0} or {3,2}.
  - Word writes the full word.
  - Other lanes are unchanged.
  - The write is visible to any request from the next cycle on.
  - The following cycle gives saidaValida=0.
- Load (escrita=0): one-cycle latency; the array is read at the accepting edge.
  - Next cycle: saidaValida=1 and saida = the selected lane(s), shifted to bit 0.
  - Signed modes sign-extend from bit 7 or bit 15; unsigned modes zero-extend.
  - saida holds its value until the next valid load or reset.
- Back-to-back requests are accepted every cycle. A load immediately after a store to the same word returns the stored data.
- saidaValida and erro are never 1 in the same cycle.

Test Plan:
- Release reset with PROFUNDIDADE=256 -> ocupado=1 for exactly 256 cycles, then 0. A word load from 0x3FC then returns saida=0x00000000 with saidaValida=1 one cycle later.
- Word store 0xDEADBEEF @0x10, then lb @0x13, lbu @0x13, lh @0x12, lhu @0x10 -> saida = 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000BEEF, each one cycle after its request.
- sb 0x55 @0x11 over 0xDEADBEEF, then lw @0x10 -> 0xDEAD55EF. Back-to-back store then load in consecutive cycles returns the new value.
- lw @0x12, lh @0x21, modo=011 -> erro pulses once for each, saidaValida=0, saida unchanged. An sw @0x02 leaves the memory unchanged.
- lw @0x400 with depth 256 -> returns the word at 0x000, confirming wrap-around.
- Reset pulsed at clear count 100 and again one cycle after a load request -> clear restarts at 0, ocupado stays 1 for a full 256 cycles, and no saidaValida is produced.
